// File: rtl/tc_mul_pipe_su.sv
// Pipelined signed x unsigned multiplier with ready/valid flow control and a sideband tag.
// Define TC_MUL_SAT_EN to saturate dout on overflow instead of wrapping.
module tc_mul_pipe_su #(
  parameter int A_W    = 18,
  parameter int B_W    = 10,
  parameter int SHIFT  = 0,
  parameter int DOUT_W = 28,
  parameter int STAGES = 3,
  parameter int TAG_W  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A_W-1:0]    din0,
  input  logic [B_W-1:0]    din1,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] dout,
  output logic [TAG_W-1:0]  out_tag,
  output logic              dout_ovf
);

  localparam int P_W = A_W + B_W;

`ifdef TC_MUL_SAT_EN
  localparam logic [DOUT_W-1:0] SAT_MIN = DOUT_W'(1'b1) << (DOUT_W - 1);
  localparam logic [DOUT_W-1:0] SAT_MAX = ~SAT_MIN;
`endif

  // Value fits the signed DOUT_W range when every bit above the new sign bit matches it.
  function automatic logic fits_dout(input logic [P_W-1:0] s);
    logic [P_W-DOUT_W:0] top;
    top = s[P_W-1:DOUT_W-1];
    return (top == '0) || (top == '1);
  endfunction

  logic signed [P_W-1:0] a_ext_s;
  logic signed [P_W-1:0] b_ext_s;
  logic signed [P_W-1:0] prod_s;
  logic signed [P_W-1:0] shr_s;
  logic                  ovf_s;
  logic [DOUT_W-1:0]     res_s;

  logic [STAGES:1]       v_r;
  logic [STAGES:1]       ovf_r;
  logic [STAGES:1]       adv_s;
  logic [DOUT_W-1:0]     dout_r [1:STAGES];
  logic [TAG_W-1:0]      tag_r  [1:STAGES];

  // Full-width product, shift and output narrowing; registers behind it are retiming-friendly.
  always_comb begin
    a_ext_s = {{B_W{din0[A_W-1]}}, din0};
    b_ext_s = {{A_W{1'b0}}, din1};
    prod_s  = a_ext_s * b_ext_s;
    shr_s   = prod_s >>> SHIFT;
    ovf_s   = !fits_dout(shr_s);
`ifdef TC_MUL_SAT_EN
    if (ovf_s) begin
      res_s = shr_s[P_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      res_s = shr_s[DOUT_W-1:0];
    end
`else
    res_s = shr_s[DOUT_W-1:0];
`endif
  end

  // A stage may advance if it or any stage after it is a bubble, or the consumer takes the head.
  always_comb begin : adv_chain
    logic open_s;
    open_s = out_ready;
    adv_s  = '0;
    for (int k = STAGES; k >= 1; k--) begin
      open_s   = open_s || !v_r[k];
      adv_s[k] = open_s;
    end
  end

  // Stage registers: valid always follows on advance, payload only moves with a real beat.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      v_r   <= '0;
      ovf_r <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        dout_r[k] <= '0;
        tag_r[k]  <= '0;
      end
    end else begin
      if (adv_s[1]) begin
        v_r[1] <= in_valid;
        if (in_valid) begin
          dout_r[1] <= res_s;
          tag_r[1]  <= in_tag;
          ovf_r[1]  <= ovf_s;
        end
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (adv_s[k]) begin
          v_r[k] <= v_r[k-1];
          if (v_r[k-1]) begin
            dout_r[k] <= dout_r[k-1];
            tag_r[k]  <= tag_r[k-1];
            ovf_r[k]  <= ovf_r[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = adv_s[1];
  assign out_valid = v_r[STAGES];
  assign dout      = dout_r[STAGES];
  assign out_tag   = tag_r[STAGES];
  assign dout_ovf  = ovf_r[STAGES];

endmodule

// File: tb/tb_tc_mul_pipe_su.sv
// Directed self-checking bench for tc_mul_pipe_su: default, SHIFT=2 and DOUT_W=16 instances
// share one input stream; backpressure, bubble collapse and mid-stream reset use the default one.
module tb_tc_mul_pipe_su;

  logic        ap_clk;
  logic        ap_rst;
  logic        in_valid;
  logic        out_ready;
  logic [17:0] din0;
  logic [9:0]  din1;
  logic [7:0]  in_tag;

  logic        ready_def, valid_def, ovf_def;
  logic [27:0] dout_def;
  logic [7:0]  tag_def;
  logic        ready_sh, valid_sh, ovf_sh;
  logic [27:0] dout_sh;
  logic [7:0]  tag_sh;
  logic        ready_nw, valid_nw, ovf_nw;
  logic [15:0] dout_nw;
  logic [7:0]  tag_nw;

  int checks = 0;
  int errors = 0;

  tc_mul_pipe_su u_def (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ready_def),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(valid_def), .out_ready(out_ready),
    .dout(dout_def), .out_tag(tag_def), .dout_ovf(ovf_def)
  );

  tc_mul_pipe_su #(.SHIFT(2)) u_shift (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ready_sh),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(valid_sh), .out_ready(out_ready),
    .dout(dout_sh), .out_tag(tag_sh), .dout_ovf(ovf_sh)
  );

  tc_mul_pipe_su #(.DOUT_W(16)) u_narrow (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(ready_nw),
    .din0(din0), .din1(din1), .in_tag(in_tag), .out_valid(valid_nw), .out_ready(out_ready),
    .dout(dout_nw), .out_tag(tag_nw), .dout_ovf(ovf_nw)
  );

  localparam int NV = 10;
  localparam longint VA   [NV] = '{-131072, 131071, -5, 5, 1000, -1000, 0, -1, -32768, 32768};
  localparam longint VB   [NV] = '{1023, 1023, 3, 3, 1000, 1000, 0, 1, 1, 1};
  localparam longint VT   [NV] = '{90, 165, 1, 2, 3, 4, 255, 5, 16, 17};
  localparam longint E_DF [NV] = '{-134086656, 134085633, -15, 15, 1000000, -1000000, 0, -1, -32768, 32768};
  localparam longint E_SH [NV] = '{-33521664, 33521408, -4, 3, 250000, -250000, 0, -1, -8192, 8192};
  localparam longint E_NW [NV] = '{0, -1023, -15, 15, 16960, -16960, 0, -1, -32768, -32768};
  localparam longint E_NS [NV] = '{-32768, 32767, -15, 15, 32767, -32768, 0, -1, -32768, 32767};
  localparam longint O_NW [NV] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 1};

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    in_tag    = '0;
    repeat (2) @(posedge ap_clk);
    #3;
    ap_rst = 1'b0;
    tick();
  endtask

  function automatic longint bp_a(input int t);
    return (t % 2 == 1) ? -(t * 4001) : t * 3999;
  endfunction

  int     sent, rcv, cnt, idx;
  logic   acc, cons, hold;
  longint held_d;
  longint held_t;

  initial begin
    do_reset();
    check("rst_valid", valid_def, 1'b0);
    check("rst_dout", dout_def, 28'd0);
    check("rst_tag", tag_def, 8'd0);
    check("rst_ovf", ovf_def, 1'b0);
    check("rst_ready", ready_def, 1'b1);

    // Back-to-back directed vectors, out_ready high: latency STAGES, one beat per cycle.
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) begin
        in_valid = 1'b1;
        din0     = 18'(VA[c]);
        din1     = 10'(VB[c]);
        in_tag   = 8'(VT[c]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("s_ready", ready_def && ready_sh && ready_nw, 1'b1);
      tick();
      if (c >= 2) begin
        idx = c - 2;
        check($sformatf("s_valid%0d", idx), valid_def && valid_sh && valid_nw, 1'b1);
        check($sformatf("s_tag%0d", idx), tag_def, VT[idx]);
        check($sformatf("s_dout%0d", idx), $signed(dout_def), E_DF[idx]);
        check($sformatf("s_ovf%0d", idx), ovf_def, 1'b0);
        check($sformatf("sh_dout%0d", idx), $signed(dout_sh), E_SH[idx]);
        check($sformatf("sh_ovf%0d", idx), ovf_sh, 1'b0);
        check($sformatf("sh_tag%0d", idx), tag_sh, VT[idx]);
        check($sformatf("nw_tag%0d", idx), tag_nw, VT[idx]);
        check($sformatf("nw_ovf%0d", idx), ovf_nw, O_NW[idx]);
`ifdef TC_MUL_SAT_EN
        check($sformatf("nw_dout%0d", idx), $signed(dout_nw), E_NS[idx]);
`else
        check($sformatf("nw_dout%0d", idx), $signed(dout_nw), E_NW[idx]);
`endif
      end else begin
        check($sformatf("s_lat%0d", c), valid_def, 1'b0);
      end
    end
    in_valid = 1'b0;
    tick();
    check("s_drain", valid_def, 1'b0);

    // Backpressure: tags 1..10 back-to-back, consumer stalls in cycles 4..9.
    do_reset();
    sent = 0; rcv = 0; cnt = 0; hold = 1'b0; held_d = 0; held_t = 0;
    for (int c = 1; c <= 40; c++) begin
      out_ready = !(c >= 4 && c <= 9);
      if (sent < 10) begin
        in_valid = 1'b1;
        din0     = 18'(bp_a(sent + 1));
        din1     = 10'((sent + 1) * 97);
        in_tag   = 8'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bp_ready", ready_def, (cnt < 3 || out_ready) ? 1'b1 : 1'b0);
      if (hold) begin
        check("bp_hold_v", valid_def, 1'b1);
        check("bp_hold_d", $signed(dout_def), held_d);
        check("bp_hold_t", tag_def, held_t);
      end
      acc  = in_valid && ready_def;
      cons = valid_def && out_ready;
      if (cons) begin
        check($sformatf("bp_tag%0d", rcv + 1), tag_def, rcv + 1);
        check($sformatf("bp_dout%0d", rcv + 1), $signed(dout_def), bp_a(rcv + 1) * (rcv + 1) * 97);
        rcv++;
      end
      hold   = valid_def && !out_ready;
      held_d = $signed(dout_def);
      held_t = tag_def;
      cnt    = cnt + int'(acc) - int'(cons);
      sent   = sent + int'(acc);
      tick();
    end
    check("bp_count", rcv, 10);

    // Bubble collapse: A, idle, B; consumer stalls once A is at the head.
    do_reset();
    in_valid = 1'b1; din0 = 18'd77; din1 = 10'd5; in_tag = 8'hA1;
    #1; check("b_rdy_a", ready_def, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; din0 = -18'sd300; din1 = 10'd7; in_tag = 8'hB2;
    #1; check("b_rdy_b", ready_def, 1'b1);
    tick();
    check("b_head_v", valid_def, 1'b1);
    check("b_head_t", tag_def, 8'hA1);
    out_ready = 1'b0; in_valid = 1'b0;
    #1; check("b_rdy_gap", ready_def, 1'b1);
    tick();
    check("b_stall_d", $signed(dout_def), 385);
    in_valid = 1'b1; din0 = 18'd12; din1 = 10'd1000; in_tag = 8'hC3;
    #1; check("b_rdy_c", ready_def, 1'b1);
    tick();
    in_valid = 1'b0;
    #1; check("b_full", ready_def, 1'b0);
    check("b_stall_t", tag_def, 8'hA1);
    out_ready = 1'b1;
    #1; check("b_rdy_comb", ready_def, 1'b1);
    tick();
    check("b_next_t", tag_def, 8'hB2);
    check("b_next_d", $signed(dout_def), -2100);
    tick();
    check("b_last_t", tag_def, 8'hC3);
    check("b_last_d", $signed(dout_def), 12000);
    tick();
    check("b_empty", valid_def, 1'b0);

    // Mid-stream reset drops everything in flight; next beat has full latency.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; din0 = 18'(100 + i); din1 = 10'd2; in_tag = 8'(31 + i);
      tick();
    end
    in_valid = 1'b0;
    check("r_pre_v", valid_def, 1'b1);
    #2;
    ap_rst = 1'b1;
    #1;
    check("r_async_v", valid_def, 1'b0);
    check("r_async_d", dout_def, 28'd0);
    check("r_async_t", tag_def, 8'd0);
    @(posedge ap_clk);
    #3;
    ap_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r_stale", valid_def, 1'b0);
    end
    in_valid = 1'b1; din0 = -18'sd7; din1 = 10'd9; in_tag = 8'd44;
    tick();
    in_valid = 1'b0;
    check("r_lat1", valid_def, 1'b0);
    tick();
    check("r_lat2", valid_def, 1'b0);
    tick();
    check("r_lat3", valid_def, 1'b1);
    check("r_dout", $signed(dout_def), -63);
    check("r_tag", tag_def, 8'd44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
